booth_radix4_multiplier: RTL

- Sequential radix-4 (modified) Booth multiplier. Successor to the radix-2 shift/add Booth multiplier.
- Retires two multiplier bits per cycle and takes a runtime signed/unsigned mode select.
- Offers a start/ready/done handshake with zero-operand early termination.
- Sits in the arithmetic datapath as a multi-cycle multiply resource driven by a sequencer.

---
 rtl/booth_pkg.sv | 25 ++
 rtl/booth_r4_encoder.sv | 23 ++
 rtl/booth_radix4_multiplier.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth multiplier.
//   state_t       : sequencer states (S_IDLE, S_RUN, S_DONE)
//   booth_digit_t : recoded digit control {neg, one, two}
//   DIGIT_*       : control words for the digits 0, +1, +2, -1, -2
package booth_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic neg;
        logic one;
        logic two;
    } booth_digit_t;

    localparam booth_digit_t DIGIT_ZERO = '{neg: 1'b0, one: 1'b0, two: 1'b0};
    localparam booth_digit_t DIGIT_POS1 = '{neg: 1'b0, one: 1'b1, two: 1'b0};
    localparam booth_digit_t DIGIT_POS2 = '{neg: 1'b0, one: 1'b0, two: 1'b1};
    localparam booth_digit_t DIGIT_NEG1 = '{neg: 1'b1, one: 1'b1, two: 1'b0};
    localparam booth_digit_t DIGIT_NEG2 = '{neg: 1'b1, one: 1'b0, two: 1'b1};

endpackage

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth recoder: maps the multiplier triplet {Q[1], Q[0], q_prev}
// to a digit in {-2, -1, 0, +1, +2}.
//   triplet : input  3-bit window of the multiplier
//   digit   : output {neg, one, two} control for the partial product
module booth_r4_encoder
    import booth_pkg::*;
(
    input  logic [2:0]   triplet,
    output booth_digit_t digit
);

    always_comb begin
        digit = DIGIT_ZERO;
        case (triplet)
            3'b001, 3'b010: digit = DIGIT_POS1;
            3'b011:         digit = DIGIT_POS2;
            3'b100:         digit = DIGIT_NEG2;
            3'b101, 3'b110: digit = DIGIT_NEG1;
            default:        digit = DIGIT_ZERO;
        endcase
    end

endmodule

// File: rtl/booth_radix4_multiplier.sv
// Sequential radix-4 Booth multiplier with runtime signed/unsigned mode.
// Retires two multiplier bits per cycle; zero operands finish in one edge.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   start        : request, accepted when ready=1
//   signed_mode  : 1 = two's complement operands, 0 = unsigned
//   word1, word2 : multiplicand / multiplier, sampled on the accepting edge
//   ready        : a new start is accepted (S_IDLE or S_DONE)
//   busy         : iterating (S_RUN)
//   done         : product valid this cycle (S_DONE)
//   product      : 2*WIDTH-bit result, held until the next done
module booth_radix4_multiplier
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     word1,
    input  logic [WIDTH-1:0]     word2,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int ITER = WIDTH / 2 + 1;
    localparam int EW   = WIDTH + 2;
    localparam int AW   = 2 * WIDTH + 4;
    localparam int CW   = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    state_t          state, state_next;
    logic [EW-1:0]   m_reg;
    logic [EW-1:0]   q_reg;
    logic            q_prev;
    logic [AW-1:0]   acc;
    logic [CW-1:0]   cnt;

    logic            accept;
    logic            zero_op;
    logic            last;
    logic [EW-1:0]   word1_ext;
    logic [EW-1:0]   word2_ext;
    booth_digit_t    digit;
    logic [AW-1:0]   m_wide;
    logic [AW-1:0]   pp_mag;
    logic [AW-1:0]   pp_signed;
    logic [AW-1:0]   acc_sum;

    // Two extra bits let -2^(W-1) (signed) and 2^W-1 (unsigned) share one datapath.
    assign word1_ext = {{2{signed_mode & word1[WIDTH-1]}}, word1};
    assign word2_ext = {{2{signed_mode & word2[WIDTH-1]}}, word2};
    assign zero_op   = (word1 == '0) || (word2 == '0);
    assign last      = (cnt == LAST);

    booth_r4_encoder u_encoder (
        .triplet ({q_reg[1:0], q_prev}),
        .digit   (digit)
    );

    // Shifted-operand form: the partial product is aligned by 4^cnt instead
    // of shifting the accumulator.
    always_comb begin
        m_wide    = {{(AW - EW){m_reg[EW-1]}}, m_reg};
        pp_mag    = '0;
        if (digit.two) begin
            pp_mag = m_wide << 1;
        end else if (digit.one) begin
            pp_mag = m_wide;
        end
        pp_signed = digit.neg ? (~pp_mag + 1'b1) : pp_mag;
        acc_sum   = acc + (pp_signed << {cnt, 1'b0});
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    state_next = zero_op ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                ready = 1'b1;
                done  = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    state_next = zero_op ? S_DONE : S_RUN;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m_reg   <= '0;
            q_reg   <= '0;
            q_prev  <= 1'b0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
        end else if (accept) begin
            m_reg  <= word1_ext;
            q_reg  <= word2_ext;
            q_prev <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
            if (zero_op) begin
                product <= '0;
            end
        end else if (state == S_RUN) begin
            acc    <= acc_sum;
            q_reg  <= {{2{q_reg[EW-1]}}, q_reg[EW-1:2]};
            q_prev <= q_reg[1];
            cnt    <= cnt + 1'b1;
            if (last) begin
                product <= acc_sum[2*WIDTH-1:0];
            end
        end
    end

endmodule
